// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle for seq_alu.
//   master: drives in_valid/op/a/b/set_flags and out_ready; sees in_ready and results.
//   slave : the ALU side of the same signals.
interface seq_alu_if #(
  parameter int unsigned W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;

  modport master (
    output in_valid, op, a, b, set_flags, out_ready,
    input  in_ready, out_valid, result, flags, err
  );

  modport slave (
    input  in_valid, op, a, b, set_flags, out_ready,
    output in_ready, out_valid, result, flags, err
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with registered {N,Z,C,V} flags.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : seq_alu_if.slave (valid/ready request in, valid/ready result out)
// Single-cycle ops finish one cycle after accept; MUL (and DIV when SEQ_ALU_DIV_EN is
// defined) iterate for W cycles in StBusy. Without SEQ_ALU_DIV_EN op 1101 is illegal.
module seq_alu #(
  parameter int unsigned W   = 16,
  parameter int unsigned SHW = $clog2(W)
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);
  localparam int unsigned CW = $clog2(W);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSubA = 4'h1;
  localparam logic [3:0] OpSubB = 4'h2;
  localparam logic [3:0] OpBic  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpXnor = 4'h7;
  localparam logic [3:0] OpAdc  = 4'h8;
  localparam logic [3:0] OpLsl  = 4'h9;
  localparam logic [3:0] OpLsr  = 4'hA;
  localparam logic [3:0] OpAsr  = 4'hB;
  localparam logic [3:0] OpMul  = 4'hC;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OpDiv  = 4'hD;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  logic           err_q, err_d;
  logic [3:0]     flags_q, flags_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Iteration register: MUL {acc_hi, multiplier}, DIV {remainder, dividend/quotient}.
  logic [2*W-1:0] work_q, work_d;
  logic [W-1:0]   a_q, a_d;
  logic           set_flags_q, set_flags_d;
`ifdef SEQ_ALU_DIV_EN
  logic [W-1:0]   b_q, b_d;
  logic           div_q, div_d;
`endif

  logic accept;
  assign bus.in_ready  = (state_q == StIdle) & ~reset;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.flags     = flags_q;

  // Single-cycle datapath, evaluated on the operands present at accept.
  logic [W-1:0]   add_x, add_y;
  logic           add_cin;
  logic [W:0]     add_sum, shl_t, shr_t, sar_t;
  logic [SHW-1:0] amt;
  logic [W-1:0]   sc_res;
  logic           sc_c, sc_v, sc_err;

  always_comb begin
    amt     = bus.b[SHW-1:0];
    add_x   = bus.a;
    add_y   = bus.b;
    add_cin = 1'b0;
    case (bus.op)
      OpSubA:  begin add_y = ~bus.b; add_cin = 1'b1; end
      OpSubB:  begin add_x = bus.b; add_y = ~bus.a; add_cin = 1'b1; end
      OpAdc:   add_cin = flags_q[1];
      default: ;
    endcase
    // Subtraction as x + ~y + 1: carry out is the "no borrow" flag directly.
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    // One extra bit on the shifted-out side captures the last bit shifted out.
    shl_t   = {1'b0, bus.a} << amt;
    shr_t   = {bus.a, 1'b0} >> amt;
    sar_t   = $signed({bus.a, 1'b0}) >>> amt;

    sc_res = '0;
    sc_c   = flags_q[1];
    sc_v   = flags_q[0];
    sc_err = 1'b0;
    case (bus.op)
      OpAdd, OpSubA, OpSubB, OpAdc: begin
        sc_res = add_sum[W-1:0];
        sc_c   = add_sum[W];
        sc_v   = (add_x[W-1] == add_y[W-1]) && (add_sum[W-1] != add_x[W-1]);
      end
      OpBic:  begin sc_res = bus.a & ~bus.b;   sc_c = 1'b0; sc_v = 1'b0; end
      OpAnd:  begin sc_res = bus.a & bus.b;    sc_c = 1'b0; sc_v = 1'b0; end
      OpOr:   begin sc_res = bus.a | bus.b;    sc_c = 1'b0; sc_v = 1'b0; end
      OpXor:  begin sc_res = bus.a ^ bus.b;    sc_c = 1'b0; sc_v = 1'b0; end
      OpXnor: begin sc_res = ~(bus.a ^ bus.b); sc_c = 1'b0; sc_v = 1'b0; end
      OpLsl: begin
        sc_res = shl_t[W-1:0];
        if (amt != '0) sc_c = shl_t[W];
      end
      OpLsr: begin
        sc_res = shr_t[W:1];
        if (amt != '0) sc_c = shr_t[0];
      end
      OpAsr: begin
        sc_res = sar_t[W:1];
        if (amt != '0) sc_c = sar_t[0];
      end
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration step of the multiplier / divider.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] step_next;
  logic [W-1:0]   step_res;
  logic           step_c, step_v;
`ifdef SEQ_ALU_DIV_EN
  logic [W:0]     div_sh;
  logic [W-1:0]   div_diff;
  logic           div_ge;
`endif

  always_comb begin
    mul_sum   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, a_q} : '0);
    step_next = {mul_sum, work_q[W-1:1]};
    step_res  = step_next[W-1:0];
    step_c    = |step_next[2*W-1:W];
    step_v    = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    div_sh   = {work_q[2*W-1:W], work_q[W-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    // When div_ge holds the difference fits in W bits.
    div_diff = div_sh[W-1:0] - b_q;
    if (div_q) begin
      // b == 0 makes every trial succeed, giving an all-ones quotient.
      step_next = div_ge ? {div_diff, work_q[W-2:0], 1'b1}
                         : {div_sh[W-1:0], work_q[W-2:0], 1'b0};
      step_res  = step_next[W-1:0];
      step_c    = 1'b0;
      step_v    = (b_q == '0);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    err_d       = err_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    a_d         = a_q;
    set_flags_d = set_flags_q;
`ifdef SEQ_ALU_DIV_EN
    b_d         = b_q;
    div_d       = div_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d         = bus.a;
          set_flags_d = bus.set_flags;
          cnt_d       = '0;
          if (bus.op == OpMul) begin
            state_d = StBusy;
            work_d  = {{W{1'b0}}, bus.b};
`ifdef SEQ_ALU_DIV_EN
            div_d   = 1'b0;
          end else if (bus.op == OpDiv) begin
            state_d = StBusy;
            work_d  = {{W{1'b0}}, bus.a};
            b_d     = bus.b;
            div_d   = 1'b1;
`endif
          end else begin
            state_d  = StDone;
            result_d = sc_res;
            err_d    = sc_err;
            if (bus.set_flags && !sc_err) begin
              flags_d = {sc_res[W-1], sc_res == '0, sc_c, sc_v};
            end
          end
        end
      end
      StBusy: begin
        work_d = step_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d  = StDone;
          result_d = step_res;
          err_d    = 1'b0;
          if (set_flags_q) flags_d = {step_res[W-1], step_res == '0, step_c, step_v};
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      result_q    <= '0;
      err_q       <= 1'b0;
      flags_q     <= 4'b0000;
      cnt_q       <= '0;
      work_q      <= '0;
      a_q         <= '0;
      set_flags_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      b_q         <= '0;
      div_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      err_q       <= err_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      a_q         <= a_d;
      set_flags_q <= set_flags_d;
`ifdef SEQ_ALU_DIV_EN
      b_q         <= b_d;
      div_q       <= div_d;
`endif
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed plus random checks of seq_alu (W=16) against an arithmetic model.
module tb_seq_alu;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seq_alu_if #(.W(W)) bus ();
  seq_alu #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [3:0] mflags = 4'b0000;

`ifdef SEQ_ALU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] r;
    logic        err;
    logic [3:0]  f;
    logic [5:0]  lat;
  } ref_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic ref_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic sf, input logic [3:0] fl);
    ref_t o;
    logic [31:0] p;
    int sa, sb, amt;
    logic c, v, err;
    logic [15:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    amt = int'(b[3:0]);
    c = fl[1];
    v = fl[0];
    err = 1'b0;
    r = '0;
    p = '0;
    case (op)
      4'd0: begin p = {16'b0, a} + {16'b0, b}; r = p[15:0]; c = p[16]; v = ovf(sa + sb); end
      4'd1: begin r = a - b; c = (a >= b); v = ovf(sa - sb); end
      4'd2: begin r = b - a; c = (b >= a); v = ovf(sb - sa); end
      4'd3: begin r = a & ~b; c = 0; v = 0; end
      4'd4: begin r = a & b; c = 0; v = 0; end
      4'd5: begin r = a | b; c = 0; v = 0; end
      4'd6: begin r = a ^ b; c = 0; v = 0; end
      4'd7: begin r = ~(a ^ b); c = 0; v = 0; end
      4'd8: begin
        p = {16'b0, a} + {16'b0, b} + {31'b0, fl[1]};
        r = p[15:0]; c = p[16]; v = ovf(sa + sb + int'(fl[1]));
      end
      4'd9: begin p = {16'b0, a} << amt; r = p[15:0]; if (amt != 0) c = p[16]; end
      4'd10: begin r = a >> amt; if (amt != 0) c = a[amt-1]; end
      4'd11: begin r = 16'($signed(a) >>> amt); if (amt != 0) c = a[amt-1]; end
      4'd12: begin p = {16'b0, a} * {16'b0, b}; r = p[15:0]; c = (p[31:16] != 0); v = 0; end
      4'd13: begin
        if (DivEn) begin
          if (b == 0) begin r = 16'hFFFF; v = 1; end
          else begin r = a / b; v = 0; end
          c = 0;
        end else err = 1'b1;
      end
      default: err = 1'b1;
    endcase
    if (err) r = '0;
    o.r = r;
    o.err = err;
    o.f = (sf && !err) ? {r[15], r == 16'h0, c, v} : fl;
    o.lat = ((op == 4'd12) || (DivEn && op == 4'd13)) ? 6'd17 : 6'd1;
    return o;
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic sf, input int hold,
                       output logic [15:0] r_o, output logic [3:0] f_o);
    ref_t e;
    int lat;
    e = model(op, a, b, sf, mflags);
    @(negedge clk);
    chk("in_ready idle", bus.in_ready, 1);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.set_flags = sf;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk("in_ready low", bus.in_ready, 0);
    end while (!bus.out_valid && lat < 100);
    chk("latency", lat, e.lat);
    chk("result", bus.result, e.r);
    chk("err", bus.err, e.err);
    chk("flags", bus.flags, e.f);
    r_o = bus.result;
    f_o = bus.flags;
    mflags = e.f;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.op = 4'($urandom_range(0, 11));
      bus.a = 16'($urandom);
      @(negedge clk);
      chk("hold out_valid", bus.out_valid, 1);
      chk("hold result", bus.result, e.r);
      chk("hold flags", bus.flags, e.f);
      chk("hold in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("drained out_valid", bus.out_valid, 0);
    chk("in_ready after", bus.in_ready, 1);
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0] f;
    logic seen;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.set_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst result", bus.result, 0);
    chk("rst err", bus.err, 0);
    chk("rst flags", bus.flags, 0);

    do_op(4'd0, 16'h7FFF, 16'h0001, 1'b1, 0, r, f);
    chk("add ovf result", r, 16'h8000);
    chk("add ovf flags", f, 4'b1001);
    do_op(4'd0, 16'hFFFF, 16'h0001, 1'b1, 0, r, f);
    chk("add wrap flags", f, 4'b0110);
    do_op(4'd8, 16'h0001, 16'h0001, 1'b1, 0, r, f);
    chk("adc result", r, 16'h0003);
    do_op(4'd1, 16'h0003, 16'h0005, 1'b1, 0, r, f);
    chk("sub result", r, 16'hFFFE);
    do_op(4'd12, 16'h0100, 16'h0100, 1'b1, 0, r, f);
    chk("mul flags", f, 4'b0110);
    do_op(4'd13, 16'd100, 16'd7, 1'b1, 0, r, f);
    chk("div result", r, DivEn ? 16'h000E : 16'h0000);
    do_op(4'd13, 16'd5, 16'd0, 1'b1, 0, r, f);
    do_op(4'd14, 16'h1234, 16'h5678, 1'b1, 0, r, f);
    do_op(4'd9, 16'h8001, 16'h0001, 1'b1, 5, r, f);
    chk("lsl result", r, 16'h0002);
    chk("lsl carry", f[1], 1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.op = 4'd12;
    bus.a = 16'h1234;
    bus.b = 16'h00FF;
    bus.set_flags = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort in_ready", bus.in_ready, 1);
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort flags", bus.flags, 0);
    mflags = 4'b0000;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort no result", seen, 0);
    do_op(4'd0, 16'd2, 16'd3, 1'b0, 0, r, f);
    chk("add after reset", r, 16'h0005);

    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 2), r, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the team's combinational ALU, used by the multi-cycle datapath.
- Adds registered N/Z/C/V flags, add-with-carry, shifts and an iterative multiplier and divider.
- Input and output each use a valid/ready handshake.
- Single-cycle ops complete in 1 cycle; multiply and divide take W cycles of iteration.

Parameters:
- W, 16: operand/result width; power of two, at least 4.
- SHW, $clog2(W): width of the shift amount taken from b.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high when the block can accept a request.
- op  input  4  operation select.
- a  input  W  operand A.
- b  input  W  operand B.
- set_flags  input  1  update the flag register when this op completes.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  W  registered result.
- flags  output  4  flag register {N,Z,C,V}.
- err  output  1  registered with result: illegal op.

Behaviour:
- State machine has three states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) & ~reset.
- Accept occurs on in_valid & in_ready; a, b, op, set_flags and the current C flag are latched.
- Single-cycle ops (0000-1011): IDLE -> DONE; out_valid is high on the cycle after accept.
- MUL (1100) and DIV (1101): IDLE -> BUSY for W cycles -> DONE; out_valid is high W+1 cycles after accept.
- DONE holds result, err and out_valid stable until out_valid & out_ready, then moves to IDLE. in_ready rises the following cycle.
- Requests arriving while not IDLE are ignored.
- Flag register update happens only on entry to DONE, only when the latched set_flags=1 and err=0.
- N = result[W-1]; Z = (result==0) for all ops.
- 0000 ADD a+b: C = carry out; V = signed overflow.
- 0001 SUB a-b and 0010 SUB b-a: C = 1 when there is no borrow (minuend >= subtrahend, unsigned); V = signed overflow.
- 0011 BIC a&~b, 0100 AND, 0101 OR, 0110 XOR, 0111 XNOR: C=0, V=0.
- 1000 ADC a+b+C, using the latched C flag: C and V as for ADD.
- 1001 LSL, 1010 LSR, 1011 ASR: shift a by b[SHW-1:0]. C = last bit shifted out; amount 0 leaves C unchanged. V unchanged.
- 1100 MUL: unsigned shift-add, one partial product per cycle; result = low W bits. C = 1 when the high W bits are nonzero; V=0.
- 1101 DIV: unsigned restoring division, one quotient bit per cycle; result = quotient. For b==0 the result is all ones and V=1; otherwise V=0. C=0.
- 1110 and 1111 are illegal: single-cycle, result=0, err=1, flags unchanged.
- Reset: state IDLE, out_valid=0, result=0, err=0, flags=0000, iteration counters cleared.
- Reset during BUSY or DONE aborts the operation; no result is delivered.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- Defined: op 1101 is the iterative divider described above.
- Undefined: divider logic is omitted; 1101 is treated as illegal (single-cycle, result=0, err=1, flags unchanged).

Test Plan:
- ADD a=0x7FFF b=0x0001 set_flags=1 -> out_valid 1 cycle after accept; result=0x8000; flags N=1 Z=0 C=0 V=1.
- ADD 0xFFFF+0x0001 set_flags=1 -> result 0x0000, Z=1 C=1. Then ADC 0x0001+0x0001 -> result 0x0003. Then SUB 0x0003-0x0005 -> 0xFFFE with N=1 C=0 V=0.
- MUL 0x0100*0x0100 set_flags=1 -> in_ready=0 throughout; out_valid exactly 17 cycles after accept; result=0x0000, Z=1 C=1.
- DIV 100/7 -> result 0x000E. DIV 5/0 -> result 0xFFFF, V=1. With SEQ_ALU_DIV_EN undefined: op 1101 -> result 0, err=1, flags unchanged.
- Backpressure: hold out_ready=0 for 5 cycles after a LSL 0x8001 by 1 -> result 0x0002 with C=1 stable throughout; in_valid pulses in that window are ignored.
- Assert reset on cycle 8 of a MUL -> out_valid=0, flags=0000; in_ready=1 in the first cycle after reset deasserts; a following ADD 2+3 returns 0x0005.
